// File: rtl/iob_cache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_req_arbiter_pkg
// Description : Shared types for the cache IOb request arbiter. This file
//               holds the arbiter state encoding and a small helper to
//               decode the busy indication from the state.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_cache_req_arbiter_pkg;

    // The numeric values are fixed so that debug probes and traces decode
    // the state the same way across every integration of this block.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_HOLD    = 2'd1,
        ARB_RD_WAIT = 2'd2
    } arb_state_t;

    // The arbiter is busy whenever it owes something to a requester.
    // That is either a request it has to keep presenting, or a read
    // response it has to route back.
    function automatic logic arb_is_busy(input arb_state_t state);
        return (state != ARB_IDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cache_req_arbiter_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : iob_rr_prio_sel
// Description : Combinational cyclic first-one search. It returns the index
//               of the first set bit of req, scanning upward from ptr+1 and
//               wrapping around, so the requester at ptr gets lowest priority.
// Ports       : req     in  N           request vector
//               ptr     in  clog2(N)    index of the previous winner
//               gnt     out clog2(N)    winning index (0 when none)
//               gnt_vld out 1           at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module iob_rr_prio_sel #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt,
    output logic                 gnt_vld
);

    localparam int c_IDX_W = $clog2(N);

    logic [c_IDX_W-1:0] w_idx;

    // Candidates are visited in the order ptr+1, ptr+2, ... ptr+N (mod N).
    // The first hit wins, so ptr itself is the last candidate to be tried.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = c_IDX_W'((int'(ptr) + i) % N);
            if (!gnt_vld && req[w_idx]) begin
                gnt     = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_req_arbiter
// Description : Round-robin arbiter sharing one cache IOb front-end among
//               N_REQ IOb requesters. A granted request passes straight to
//               the front-end with no added latency. A stalled request stays
//               locked to its requester until it is accepted. After a read is
//               accepted, the read's issuer keeps ownership until the read
//               data returns, so that rvalid can be routed back to it.
// Ports       : clk_i, arst_n_i, cke_i  clock, async active-low reset, enable
//               req_avalid_i/addr/wdata/wstrb  packed requester channels
//               req_ready_o, req_rvalid_o      per-requester handshakes
//               req_rdata_o                    shared read data
//               dn_*                           cache front-end channel
//               busy_o                         arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module iob_cache_req_arbiter
    import iob_cache_req_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic [N_REQ-1:0]          req_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [N_REQ-1:0]          req_rvalid_o,
    output logic [DATA_W-1:0]         req_rdata_o,
    output logic                      dn_avalid_o,
    output logic [ADDR_W-1:0]         dn_addr_o,
    output logic [DATA_W-1:0]         dn_wdata_o,
    output logic [DATA_W/8-1:0]       dn_wstrb_o,
    input  logic                      dn_ready_i,
    input  logic                      dn_rvalid_i,
    input  logic [DATA_W-1:0]         dn_rdata_i,
    output logic                      busy_o
);

    localparam int c_PTR_W  = $clog2(N_REQ);
    localparam int c_STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_PTR_W-1:0]  w_owner_nxt;

    logic [c_PTR_W-1:0]  w_gnt;
    logic                w_gnt_vld;
    logic [c_PTR_W-1:0]  w_sel;
    logic [c_STRB_W-1:0] w_sel_wstrb;
    logic                w_sel_read;
    logic                w_run;

    // Nothing may be offered or handed out while the block is frozen or
    // held in reset. The state register only advances on enabled cycles.
    assign w_run = cke_i & arst_n_i;

    iob_rr_prio_sel #(
        .N       (N_REQ)
    ) u_prio_sel (
        .req     (req_avalid_i),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_vld (w_gnt_vld)
    );

    // In HOLD the stalled requester keeps the port. Re-arbitrating here
    // could swap the address under a front-end that has already begun
    // decoding it.
    assign w_sel = (r_state == ARB_HOLD) ? r_owner : w_gnt;

    // Request fields are not registered. Requesters hold them stable until
    // they see ready, so a plain mux is enough.
    assign dn_addr_o   = req_addr_i [w_sel*ADDR_W   +: ADDR_W];
    assign dn_wdata_o  = req_wdata_i[w_sel*DATA_W   +: DATA_W];
    assign w_sel_wstrb = req_wstrb_i[w_sel*c_STRB_W +: c_STRB_W];
    assign dn_wstrb_o  = w_sel_wstrb;
    assign w_sel_read  = ~|w_sel_wstrb;

    assign req_rdata_o = dn_rdata_i;
    assign busy_o      = arb_is_busy(r_state);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ARB_IDLE;
            r_ptr   <= c_PTR_W'(N_REQ - 1);
            r_owner <= '0;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        dn_avalid_o  = 1'b0;
        req_ready_o  = '0;
        req_rvalid_o = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_run && w_gnt_vld) begin
                    dn_avalid_o        = 1'b1;
                    req_ready_o[w_sel] = dn_ready_i;
                    if (dn_ready_i) begin
                        w_ptr_nxt = w_sel;
                        if (w_sel_read) begin
                            w_owner_nxt = w_sel;
                            w_state_nxt = ARB_RD_WAIT;
                        end
                    end else begin
                        w_owner_nxt = w_gnt;
                        w_state_nxt = ARB_HOLD;
                    end
                end
            end

            ARB_HOLD: begin
                if (w_run) begin
                    if (req_avalid_i[r_owner]) begin
                        dn_avalid_o          = 1'b1;
                        req_ready_o[r_owner] = dn_ready_i;
                        if (dn_ready_i) begin
                            w_ptr_nxt   = r_owner;
                            w_state_nxt = w_sel_read ? ARB_RD_WAIT : ARB_IDLE;
                        end
                    end else begin
                        // The owner withdrew its request. Releasing the port
                        // is better than waiting for a request that will
                        // never be accepted.
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end

            ARB_RD_WAIT: begin
                // The response cycle only closes the read. A new issue waits
                // for the next cycle, so the front-end never sees an address
                // and rvalid belonging to different owners at once.
                if (w_run && dn_rvalid_i) begin
                    req_rvalid_o[r_owner] = 1'b1;
                    w_state_nxt           = ARB_IDLE;
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
